kernel_kcore_write_back_start_sink: RTL and testbench
=====================================================

KERNEL_KCORE_WRITE_BACK_START_SINK -- requirements
Module: kernel_kcore_write_back_start_sink

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2: maximum runs accepted (ap_ready seen) but not completed (ap_done seen); legal range 1..15.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of run_count and done_count.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start_empty_n, input, 1: start-token FIFO holds at least one token.
REQ-006 SHALL have port start_read, output, 1: pop one token from the start-token FIFO this cycle.
REQ-007 SHALL have port start_read_ce, output, 1: FIFO read clock-enable, constant 1 when out of reset.
REQ-008 SHALL have port enable, input, 1: gate for launching new runs.
REQ-009 SHALL have port ap_start, output, 1: start request to the downstream write-back process.
REQ-010 SHALL have port ap_ready, input, 1: process accepts the start.
REQ-011 SHALL have port ap_done, input, 1: process completed one run.
REQ-012 SHALL have port ap_continue, output, 1: acknowledge of ap_done.
REQ-013 SHALL have port busy, output, 1: state is ARMED or outstanding is non-zero.
REQ-014 SHALL have port run_count, output, CNT_WIDTH: number of accepted starts.
REQ-015 SHALL have port done_count, output, CNT_WIDTH: number of acknowledged dones.
REQ-016 SHALL have port err_unexp_done, output, 1: sticky flag, ap_done seen with outstanding == 0.

Function
REQ-017 SHALL implement an FSM with states IDLE and ARMED.
REQ-018 In IDLE, SHALL go to ARMED on the next edge when enable=1, start_empty_n=1 and outstanding < MAX_OUTSTANDING; otherwise it SHALL stay in IDLE.
REQ-019 In ARMED, SHALL drive ap_start=1 from a register and SHALL hold it until ap_ready=1, regardless of enable or start_empty_n.
REQ-020 On an ARMED cycle with ap_ready=1, SHALL assert start_read=1 combinationally, increment run_count and outstanding, and return to IDLE.
REQ-021 SHALL assert start_read in no other cycle; at most one token is popped per accepted start, and one idle cycle follows each pop so the FIFO's registered empty_n is current.
REQ-022 SHALL drive ap_continue = ap_done combinationally, so every done is acknowledged in the same cycle.
REQ-023 On ap_done=1 with outstanding > 0, SHALL decrement outstanding and increment done_count.
REQ-024 On ap_done=1 with outstanding == 0, SHALL leave outstanding and done_count unchanged and set err_unexp_done until reset.
REQ-025 When a start accept and a done occur in the same cycle, SHALL leave outstanding unchanged and increment both counters.
REQ-026 run_count and done_count SHALL wrap modulo 2^CNT_WIDTH; outstanding SHALL be 4 bits and SHALL never exceed MAX_OUTSTANDING.
REQ-027 When outstanding == MAX_OUTSTANDING, SHALL not leave IDLE even when start_empty_n=1, i.e. it holds back-pressure.

Reset
REQ-028 While reset=1, SHALL force state IDLE, ap_start=0, start_read=0, start_read_ce=0, outstanding=0, run_count=0, done_count=0, err_unexp_done=0, busy=0.
REQ-029 Reset asserted in ARMED SHALL drop ap_start immediately and SHALL pop no token.
REQ-030 ap_continue SHALL be 0 while reset=1.

Structure
REQ-031 The shared kcore package SHALL hold the FSM state encoding (IDLE=0, ARMED=1) and the defaults for MAX_OUTSTANDING and CNT_WIDTH.
REQ-032 A sub-module kernel_kcore_run_credit_cnt (up/down saturating credit counter with limit compare) SHALL hold outstanding; everything else SHALL stay flat.

Verification
REQ-033 Single run: token present, enable=1, ap_ready one cycle after ap_start, then ap_done 5 cycles later -> one start_read pulse, run_count=1, done_count=1, ap_continue pulse, busy=0 at end.
REQ-034 Credit limit: MAX_OUTSTANDING=2, 4 tokens, ap_done withheld -> exactly 2 starts accepted; ap_start stays 0 until one ap_done, then a third start follows within 2 cycles.
REQ-035 Enable drop in ARMED: enable->0 while ap_ready is stalled 10 cycles -> ap_start held high throughout; one pop when ap_ready=1; no further start.
REQ-036 Simultaneous ap_ready and ap_done with outstanding=1 -> outstanding stays 1, run_count and done_count each +1.
REQ-037 Spurious ap_done at outstanding=0 -> err_unexp_done=1 and sticky, done_count unchanged; cleared only by reset.
REQ-038 Reset asserted mid-ARMED -> ap_start=0 immediately, no start_read, all counters 0; after release, a pending token restarts via IDLE->ARMED.

Source files
------------

// File: rtl/kernel_kcore_write_back_start_sink_pkg.sv
// Shared kcore definitions: start-sink FSM encoding and default sizing.
package kernel_kcore_write_back_start_sink_pkg;

  // Launch FSM: IDLE waits for a token and a credit, ARMED holds ap_start.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } kcore_state_e;

  localparam int unsigned KCORE_MAX_OUTSTANDING = 2;
  localparam int unsigned KCORE_CNT_WIDTH       = 32;
  // Outstanding-run counter width; covers MAX_OUTSTANDING up to 15.
  localparam int unsigned KCORE_CREDIT_W        = 4;

endpackage

// File: rtl/kernel_kcore_write_back_start_sink_run_credit_cnt.sv
// Up/down saturating counter of runs accepted but not yet completed.
module kernel_kcore_run_credit_cnt
  import kernel_kcore_write_back_start_sink_pkg::*;
#(
  parameter int unsigned LIMIT = KCORE_MAX_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc,
  input  logic                      dec,
  output logic [KCORE_CREDIT_W-1:0] count,
  output logic                      at_limit,
  output logic                      is_zero
);

  localparam logic [KCORE_CREDIT_W-1:0] LIMIT_C = KCORE_CREDIT_W'(LIMIT);

  logic [KCORE_CREDIT_W-1:0] count_q;
  logic [KCORE_CREDIT_W-1:0] count_d;

  // Simultaneous inc and dec cancel; both ends saturate.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q < LIMIT_C)) begin
      count_d = count_q + KCORE_CREDIT_W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - KCORE_CREDIT_W'(1);
    end
  end

  // Credit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count    = count_q;
  assign at_limit = (count_q >= LIMIT_C);
  assign is_zero  = (count_q == '0);

endmodule

// File: rtl/kernel_kcore_write_back_start_sink.sv
// Start-token sink: pops one start token per accepted ap_start handshake,
// limits runs in flight and acknowledges every ap_done immediately.
module kernel_kcore_write_back_start_sink
  import kernel_kcore_write_back_start_sink_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = KCORE_MAX_OUTSTANDING,
  parameter int unsigned CNT_WIDTH       = KCORE_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_empty_n,
  output logic                 start_read,
  output logic                 start_read_ce,
  input  logic                 enable,
  output logic                 ap_start,
  input  logic                 ap_ready,
  input  logic                 ap_done,
  output logic                 ap_continue,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] run_count,
  output logic [CNT_WIDTH-1:0] done_count,
  output logic                 err_unexp_done
);

  kcore_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]      run_cnt_q, run_cnt_d;
  logic [CNT_WIDTH-1:0]      done_cnt_q, done_cnt_d;
  logic                      err_q, err_d;

  logic                      accept;
  logic                      done_ok;
  logic                      done_bad;
  logic [KCORE_CREDIT_W-1:0] outstanding;
  logic                      credit_full;
  logic                      credit_zero;

  // Done classification against the current credit count.
  always_comb begin
    done_ok  = ap_done && !credit_zero;
    done_bad = ap_done && credit_zero;
  end

  // Next state: launch only with a token, enable and a free credit; once
  // ARMED, wait for ap_ready regardless of the launch conditions. Returning
  // to IDLE after each pop gives the FIFO a cycle to refresh empty_n.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && start_empty_n && !credit_full) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (ap_ready) begin
          accept  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters and sticky error; counters wrap naturally.
  always_comb begin
    run_cnt_d  = run_cnt_q + CNT_WIDTH'(accept);
    done_cnt_d = done_cnt_q + CNT_WIDTH'(done_ok);
    err_d      = err_q | done_bad;
  end

  // State, counters and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      run_cnt_q  <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      done_cnt_q <= done_cnt_d;
      err_q      <= err_d;
    end
  end

  kernel_kcore_run_credit_cnt #(
    .LIMIT (MAX_OUTSTANDING)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .inc      (accept),
    .dec      (done_ok),
    .count    (outstanding),
    .at_limit (credit_full),
    .is_zero  (credit_zero)
  );

  // Handshake outputs; reset gating keeps them quiet while reset is held.
  always_comb begin
    ap_start      = (state_q == ST_ARMED);
    start_read    = accept && !reset;
    start_read_ce = !reset;
    ap_continue   = ap_done && !reset;
    busy          = (state_q == ST_ARMED) || (outstanding != '0);
  end

  assign run_count      = run_cnt_q;
  assign done_count     = done_cnt_q;
  assign err_unexp_done = err_q;

endmodule

// File: tb/tb_kernel_kcore_write_back_start_sink.sv
// Bench for the start-token sink: vector table, directed corner sequences and
// randomized traffic against a run-level reference model.
module tb_kernel_kcore_write_back_start_sink;

  localparam int MAXO = 2;
  localparam int CW   = 8;
  localparam int CMOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset, start_empty_n, enable, ap_ready, ap_done;
  logic          start_read, start_read_ce, ap_start, ap_continue, busy, err_unexp_done;
  logic [CW-1:0] run_count, done_count;

  int errs = 0;
  int checks = 0;

  // Reference: whether a start is being offered, runs in flight, totals.
  bit m_armed;
  int m_out, m_run, m_done;
  bit m_err;

  kernel_kcore_write_back_start_sink #(.MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start_empty_n(start_empty_n), .start_read(start_read),
    .start_read_ce(start_read_ce), .enable(enable), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue), .busy(busy),
    .run_count(run_count), .done_count(done_count), .err_unexp_done(err_unexp_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare every output to the reference for the current cycle.
  task automatic model_check();
    chk("ap_start", {31'd0, ap_start}, {31'd0, !reset && m_armed});
    chk("start_read", {31'd0, start_read}, {31'd0, !reset && m_armed && ap_ready});
    chk("start_read_ce", {31'd0, start_read_ce}, {31'd0, !reset});
    chk("ap_continue", {31'd0, ap_continue}, {31'd0, !reset && ap_done});
    chk("busy", {31'd0, busy}, {31'd0, !reset && (m_armed || m_out > 0)});
    chk("run_count", {24'd0, run_count}, reset ? 32'd0 : 32'(m_run % CMOD));
    chk("done_count", {24'd0, done_count}, reset ? 32'd0 : 32'(m_done % CMOD));
    chk("err_unexp_done", {31'd0, err_unexp_done}, {31'd0, !reset && m_err});
  endtask

  // Drive one cycle's inputs and check the settled outputs.
  task automatic apply(input logic r, input logic en, input logic emp,
                       input logic rdy, input logic dn);
    reset = r; enable = en; start_empty_n = emp; ap_ready = rdy; ap_done = dn;
    #1;
    model_check();
  endtask

  // Clock edge: advance the reference using the inputs of the ending cycle.
  task automatic tick();
    bit acc, good;
    @(posedge clk);
    if (reset) begin
      m_armed = 0; m_out = 0; m_run = 0; m_done = 0; m_err = 0;
    end else begin
      acc  = m_armed && ap_ready;
      good = ap_done && (m_out > 0);
      if (ap_done && m_out == 0) m_err = 1;
      if (m_armed) m_armed = !ap_ready;
      else         m_armed = enable && start_empty_n && (m_out < MAXO);
      m_out  = m_out + int'(acc) - int'(good);
      m_run  = m_run + int'(acc);
      m_done = m_done + int'(good);
    end
    if (m_out > MAXO) begin
      errs++;
      $display("FAIL model_outstanding: got %0d limit %0d", m_out, MAXO);
    end
    #1;
  endtask

  typedef struct packed {
    logic r, en, emp, rdy, dn;
    logic x_start, x_rd, x_ce, x_cont, x_busy;
    logic [7:0] x_run, x_done;
    logic x_err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int n, hi;
    bit seen;
    int tok;
    logic rdy, dn;

    // r en emp rdy dn | start rd ce cont busy run done err
    tbl[0]  = '{1,1,1,0,1, 0,0,0,0,0, 8'd0,8'd0, 0};
    tbl[1]  = '{0,1,1,0,0, 0,0,1,0,0, 8'd0,8'd0, 0};
    tbl[2]  = '{0,1,1,0,0, 1,0,1,0,1, 8'd0,8'd0, 0};
    tbl[3]  = '{0,1,1,1,0, 1,1,1,0,1, 8'd0,8'd0, 0};
    tbl[4]  = '{0,0,1,0,0, 0,0,1,0,1, 8'd1,8'd0, 0};
    tbl[5]  = '{0,0,1,0,1, 0,0,1,1,1, 8'd1,8'd0, 0};
    tbl[6]  = '{0,0,1,0,0, 0,0,1,0,0, 8'd1,8'd1, 0};
    tbl[7]  = '{0,0,1,0,1, 0,0,1,1,0, 8'd1,8'd1, 0};
    tbl[8]  = '{0,0,1,0,0, 0,0,1,0,0, 8'd1,8'd1, 1};
    tbl[9]  = '{0,1,1,0,0, 0,0,1,0,0, 8'd1,8'd1, 1};
    tbl[10] = '{0,1,1,1,0, 1,1,1,0,1, 8'd1,8'd1, 1};
    tbl[11] = '{0,1,1,0,0, 0,0,1,0,1, 8'd2,8'd1, 1};
    tbl[12] = '{0,1,1,1,1, 1,1,1,1,1, 8'd2,8'd1, 1};
    tbl[13] = '{0,0,1,0,0, 0,0,1,0,1, 8'd3,8'd2, 1};
    tbl[14] = '{1,0,1,0,0, 0,0,0,0,0, 8'd0,8'd0, 0};
    tbl[15] = '{0,0,1,0,0, 0,0,1,0,0, 8'd0,8'd0, 0};

    reset = 1; enable = 0; start_empty_n = 0; ap_ready = 0; ap_done = 0;
    m_armed = 0; m_out = 0; m_run = 0; m_done = 0; m_err = 0;
    #2;

    // Vector table: single run, spurious done, simultaneous ready/done, reset.
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].r, tbl[i].en, tbl[i].emp, tbl[i].rdy, tbl[i].dn);
      chk($sformatf("tbl%0d_start", i), {31'd0, ap_start}, {31'd0, tbl[i].x_start});
      chk($sformatf("tbl%0d_read", i), {31'd0, start_read}, {31'd0, tbl[i].x_rd});
      chk($sformatf("tbl%0d_ce", i), {31'd0, start_read_ce}, {31'd0, tbl[i].x_ce});
      chk($sformatf("tbl%0d_cont", i), {31'd0, ap_continue}, {31'd0, tbl[i].x_cont});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].x_busy});
      chk($sformatf("tbl%0d_run", i), {24'd0, run_count}, {24'd0, tbl[i].x_run});
      chk($sformatf("tbl%0d_done", i), {24'd0, done_count}, {24'd0, tbl[i].x_done});
      chk($sformatf("tbl%0d_err", i), {31'd0, err_unexp_done}, {31'd0, tbl[i].x_err});
      tick();
    end

    // Credit limit: tokens always present, no dones -> exactly MAXO pops.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      apply(0, 1, 1, 1, 0);
      n += int'(start_read);
      tick();
    end
    chk("credit_pops", n, MAXO);
    apply(0, 1, 1, 1, 0);
    chk("credit_backpressure", {31'd0, ap_start}, 32'd0);
    tick();
    apply(0, 1, 1, 0, 1);
    tick();
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 0, 0);
      if (ap_start) seen = 1;
      tick();
    end
    chk("credit_restart", {31'd0, seen}, 32'd1);

    // Enable drop while ARMED with ap_ready stalled.
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 1, 0, 0);
      hi += int'(ap_start);
      tick();
    end
    chk("hold_ap_start", hi, 10);
    apply(0, 0, 1, 1, 0);
    chk("hold_pop", {31'd0, start_read}, 32'd1);
    tick();
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 1, 1, 0);
      hi += int'(ap_start) + int'(start_read);
      tick();
    end
    chk("no_restart_disabled", hi, 0);

    // Reset in ARMED: drain credits, arm, then assert reset mid-cycle.
    for (int i = 0; i < 2; i++) begin apply(0, 0, 0, 0, 1); tick(); end
    apply(0, 1, 1, 0, 0); tick();
    apply(0, 1, 1, 0, 0);
    chk("armed_before_reset", {31'd0, ap_start}, 32'd1);
    apply(1, 1, 1, 1, 0);
    chk("reset_drops_start", {31'd0, ap_start}, 32'd0);
    chk("reset_no_pop", {31'd0, start_read}, 32'd0);
    chk("reset_run_count", {24'd0, run_count}, 32'd0);
    tick();
    apply(0, 1, 1, 0, 0);
    chk("post_reset_idle", {31'd0, ap_start}, 32'd0);
    tick();
    apply(0, 1, 1, 0, 0);
    chk("post_reset_rearm", {31'd0, ap_start}, 32'd1);
    tick();

    // Randomized traffic with a token FIFO; CW=8 so the counters wrap.
    apply(1, 0, 0, 0, 0); tick();
    tok = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) tok += $urandom_range(1, 3);
      rdy = ($urandom_range(0, 2) != 0);
      dn  = (m_out > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
      apply(0, $urandom_range(0, 7) != 0, tok > 0, rdy, dn);
      if (start_read) tok--;
      if (tok < 0) begin
        errs++;
        $display("FAIL fifo_underflow: got %0d required >=0", tok);
        tok = 0;
      end
      tick();
    end
    chk("random_runs_wrapped", {31'd0, m_run >= CMOD}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
